pattern_response_compactor: RTL and testbench
=============================================

Name: pattern_response_compactor

Overview:
- Consumer-side companion to the team's generated sequential/combinational test circuits.
- The test circuits drive an output vector once per applied pattern. This block receives those vectors over a valid/ready handshake, compacts them into a MISR signature, counts patterns, and compares the final signature against an expected value.
- Sits between the generated netlist's outputs and the self-test controller.

Parameters:
- WIDTH, 11, response vector width (output count of the generated circuit); must be <= SIG_W.
- SIG_W, 16, MISR/signature width.
- CNT_W, 16, pattern counter width.
- POLY, 16'h1021, MISR feedback polynomial, applied when the signature MSB = 1.

Ports:
- blif_clk_net  in  1  clock; all state updates on the rising edge.
- blif_reset_net  in  1  synchronous, active-low reset.
- start  in  1  pulse; begins a compaction run.
- abort  in  1  pulse; cancels the run and returns to IDLE.
- num_patterns  in  CNT_W  number of responses to compact; sampled on start.
- seed  in  SIG_W  initial MISR value; sampled on start.
- expected_sig  in  SIG_W  golden signature; sampled in CHECK.
- resp_valid  in  1  response vector present.
- resp_data  in  WIDTH  response vector from the circuit under test.
- resp_ready  out  1  block accepts a response this cycle.
- busy  out  1  high in RUN and CHECK.
- done  out  1  high in DONE.
- pass  out  1  signature matched; valid while done = 1.
- signature  out  SIG_W  current MISR contents.
- pattern_count  out  CNT_W  responses accepted in the current run.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (blif_reset_net sampled on the blif_clk_net rising edge).
- Reset values:
  - state = IDLE.
  - signature = 0, pattern_count = 0.
  - resp_ready = 0, busy = 0, done = 0, pass = 0.
- Reset mid-run: same values on the next edge; partial signature is discarded.
- States: IDLE, RUN, CHECK, DONE.
- IDLE:
  - On start: signature <= seed, pattern_count <= 0, target <= num_patterns.
  - Next state is RUN, or CHECK if num_patterns = 0.
- RUN:
  - resp_ready = 1, decoded combinationally from state.
  - A transfer occurs on a cycle with resp_valid & resp_ready.
  - Per transfer: signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_data); pattern_count <= pattern_count + 1.
  - When that increment reaches target, next state is CHECK; resp_ready is 0 from the following cycle.
  - No transfer: signature and count hold, with no timeout.
- CHECK: one cycle; pass <= (signature == expected_sig); next state DONE.
- DONE:
  - done = 1; signature, count and pass held.
  - start restarts exactly as from IDLE and clears pass and done on the same edge.
- abort in RUN/CHECK/DONE: next state IDLE; pass <= 0; signature and pattern_count hold for debug.
- Simultaneous events:
  - abort has priority over start and over a transfer; the transfer is not counted.
  - start is ignored in RUN and CHECK.
- Counter: pattern_count is CNT_W bits, with no wrap inside a run because target <= 2^CNT_W - 1.
- Latency: signature reflects a transfer one cycle after the handshake; done rises 2 cycles after the final transfer.

Optional Feature:
- Macro RESP_MASK_EN.
- Defined:
  - Adds port resp_mask (in, WIDTH): bit = 1 marks an unknown/X-prone output.
  - The compacted value is resp_data & ~resp_mask.
  - Mask is sampled together with the data on each transfer.
- Undefined: no resp_mask port; all resp_data bits are compacted unmasked.

Test Plan:
- Reset check: hold blif_reset_net = 0 for 2 cycles during RUN -> state IDLE, signature = 0x0000, resp_ready = 0, done = 0.
- Two-pattern run: seed = 0x0000, num_patterns = 2, responses 0x001 then 0x002, expected_sig = 0x0000.
  - signature = 0x0001 after the first transfer, 0x0000 after the second.
  - done = 1 and pass = 1 two cycles after the last transfer.
- Feedback tap: seed = 0x8000, num_patterns = 1, response 0x000, expected_sig = 0x0000 -> signature = 0x1021, pass = 0.
- Stall handling: num_patterns = 3 with resp_valid gaps of 0, 4 and 1 cycles -> pattern_count increments only on handshake cycles; final count = 3; resp_ready = 0 after CHECK.
- Zero length and abort:
  - num_patterns = 0, seed = 0x1234, expected_sig = 0x1234 -> RUN skipped; done and pass = 1 two cycles after start.
  - Separate run: abort together with resp_valid -> IDLE, pattern_count unchanged.
- RESP_MASK_EN build: seed = 0, resp_data = 0x7FF, resp_mask = 0x7FE, num_patterns = 1 -> signature = 0x0001.

Source files
------------

// File: rtl/pattern_response_compactor.sv
// Collects circuit-under-test responses over valid/ready, compacts them into a MISR
// signature and compares it with a golden value. Optional macro RESP_MASK_EN adds resp_mask.
module pattern_response_compactor #(
  parameter int unsigned      WIDTH = 11,
  parameter int unsigned      SIG_W = 16,
  parameter int unsigned      CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021)
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [SIG_W-1:0] seed,
  input  logic [SIG_W-1:0] expected_sig,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
`ifdef RESP_MASK_EN
  input  logic [WIDTH-1:0] resp_mask,
`endif
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pattern_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             pass_q, pass_d;

  logic [WIDTH-1:0] comp_data;
  logic [SIG_W-1:0] misr_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             launch;

`ifdef RESP_MASK_EN
  assign comp_data = resp_data & ~resp_mask;
`else
  assign comp_data = resp_data;
`endif

  // One MISR shift with polynomial feedback and the response folded in.
  assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(comp_data);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    pass_d   = pass_q;
    launch   = 1'b0;

    unique case (state_q)
      S_IDLE: launch = start;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (resp_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_inc;
          if (cnt_inc == target_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          pass_d  = (sig_q == expected_sig);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          launch = start;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A zero-length run skips straight to the compare.
    if (launch) begin
      sig_d    = seed;
      cnt_d    = '0;
      target_d = num_patterns;
      pass_d   = 1'b0;
      state_d  = (num_patterns == '0) ? S_CHECK : S_RUN;
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      state_q  <= S_IDLE;
      sig_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      pass_q   <= pass_d;
    end
  end

  assign resp_ready    = (state_q == S_RUN);
  assign busy          = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign signature     = sig_q;
  assign pattern_count = cnt_q;

endmodule

// File: tb/tb_pattern_response_compactor.sv
// Bench for pattern_response_compactor: directed cases plus random traffic against a run-level model.
module tb_pattern_response_compactor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] num_patterns = '0, seed = '0, expected_sig = '0;
  logic        resp_valid = 1'b0;
  logic [10:0] resp_data = '0, resp_mask = '0;
  logic        resp_ready, busy, done, pass;
  logic [15:0] signature, pattern_count;

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  pattern_response_compactor dut (
    .blif_clk_net(clk), .blif_reset_net(rst_n), .start(start), .abort(abort),
    .num_patterns(num_patterns), .seed(seed), .expected_sig(expected_sig),
    .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef RESP_MASK_EN
    .resp_mask(resp_mask),
`endif
    .resp_ready(resp_ready), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pattern_count(pattern_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Signature step as plain arithmetic: multiply by two, reduce by the polynomial on overflow.
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
    int unsigned v;
    v = 32'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ 32'h1021;
    return 16'(v) ^ d;
  endfunction

  // Run-level model: phase plus how many responses are still owed.
  localparam int P_IDLE = 0, P_RUN = 1, P_CHECK = 2, P_DONE = 3;
  int          m_phase = P_IDLE;
  int          m_left = 0;
  logic [15:0] m_sig = '0, m_cnt = '0;
  logic        m_pass = 1'b0;

  task automatic m_launch();
    m_sig   = seed;
    m_cnt   = '0;
    m_left  = int'(num_patterns);
    m_pass  = 1'b0;
    m_phase = (num_patterns == 0) ? P_CHECK : P_RUN;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_sig = '0; m_cnt = '0; m_pass = 1'b0; m_left = 0;
    end else if (abort && m_phase != P_IDLE) begin
      m_phase = P_IDLE; m_pass = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) m_launch();
        P_RUN: if (resp_valid) begin
          m_sig  = misr(m_sig, 16'(resp_data & ~resp_mask));
          m_cnt  = m_cnt + 16'd1;
          m_left = m_left - 1;
          if (m_left == 0) m_phase = P_CHECK;
        end
        P_CHECK: begin
          m_pass  = (m_sig == expected_sig);
          m_phase = P_DONE;
        end
        default: if (start) m_launch();
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("resp_ready", 32'(resp_ready), 32'(m_phase == P_RUN));
      chk("busy", 32'(busy), 32'(m_phase == P_RUN || m_phase == P_CHECK));
      chk("done", 32'(done), 32'(m_phase == P_DONE));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("signature", 32'(signature), 32'(m_sig));
      chk("pattern_count", 32'(pattern_count), 32'(m_cnt));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [15:0] np, input logic [15:0] sd, input logic [15:0] ex);
    start = 1'b1; num_patterns = np; seed = sd; expected_sig = ex;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [10:0] d, input logic [10:0] m);
    int t = 0;
    resp_valid = 1'b1; resp_data = d; resp_mask = m;
    while (!resp_ready && t < 20) begin
      cyc(1);
      t++;
    end
    chk("send_ready", 32'(resp_ready), 32'd1);
    cyc(1);
    resp_valid = 1'b0; resp_mask = '0;
  endtask

  initial begin
    cyc(2);
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    cyc(1);

    // Reset during a run
    do_start(16'd5, 16'h1234, 16'h0);
    send(11'h5, 11'h0);
    rst_n = 1'b0;
    cyc(2);
    chk("rst_sig", 32'(signature), 32'h0);
    chk("rst_ready", 32'(resp_ready), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cnt", 32'(pattern_count), 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // Two-pattern run
    do_start(16'd2, 16'h0000, 16'h0000);
    send(11'h001, 11'h0);
    chk("two_sig1", 32'(signature), 32'h0001);
    send(11'h002, 11'h0);
    chk("two_sig2", 32'(signature), 32'h0000);
    chk("two_busy_check", 32'(busy), 32'd1);
    cyc(1);
    chk("two_done", 32'(done), 32'd1);
    chk("two_pass", 32'(pass), 32'd1);

    // Feedback tap, restarted from DONE
    do_start(16'd1, 16'h8000, 16'h0000);
    chk("restart_done_clr", 32'(done), 32'd0);
    send(11'h000, 11'h0);
    chk("tap_sig", 32'(signature), 32'h1021);
    cyc(1);
    chk("tap_done", 32'(done), 32'd1);
    chk("tap_pass", 32'(pass), 32'd0);

    // Stalls between transfers
    do_start(16'd3, 16'h0000, 16'h0000);
    send(11'h001, 11'h0);
    chk("stall_cnt1", 32'(pattern_count), 32'd1);
    cyc(4);
    chk("stall_hold", 32'(pattern_count), 32'd1);
    send(11'h002, 11'h0);
    chk("stall_cnt2", 32'(pattern_count), 32'd2);
    cyc(1);
    send(11'h004, 11'h0);
    chk("stall_cnt3", 32'(pattern_count), 32'd3);
    chk("stall_sig", 32'(signature), 32'h0004);
    cyc(1);
    chk("stall_ready_off", 32'(resp_ready), 32'd0);
    chk("stall_done", 32'(done), 32'd1);

    // Zero-length run
    do_start(16'd0, 16'h1234, 16'h1234);
    chk("zero_ready", 32'(resp_ready), 32'd0);
    cyc(1);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_pass", 32'(pass), 32'd1);

    // Abort together with a valid response
    do_start(16'd4, 16'h0055, 16'h0000);
    send(11'h003, 11'h0);
    chk("abort_pre_sig", 32'(signature), 32'h00A9);
    resp_valid = 1'b1; resp_data = 11'h7; abort = 1'b1;
    cyc(1);
    resp_valid = 1'b0; abort = 1'b0;
    chk("abort_cnt", 32'(pattern_count), 32'd1);
    chk("abort_sig", 32'(signature), 32'h00A9);
    chk("abort_busy", 32'(busy), 32'd0);

`ifdef RESP_MASK_EN
    do_start(16'd1, 16'h0000, 16'h0000);
    send(11'h7FF, 11'h7FE);
    chk("mask_sig", 32'(signature), 32'h0001);
    cyc(1);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      start        = ($urandom_range(0, 99) < 8);
      abort        = ($urandom_range(0, 99) < 3);
      resp_valid   = ($urandom_range(0, 99) < 60);
      resp_data    = 11'($urandom);
      num_patterns = 16'($urandom_range(0, 6));
      seed         = 16'($urandom);
      expected_sig = $urandom_range(0, 1) ? m_sig : 16'($urandom);
`ifdef RESP_MASK_EN
      resp_mask    = 11'($urandom);
`endif
      cyc(1);
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; resp_valid = 1'b0; resp_mask = '0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
